// File: rtl/ws2812_bit_decoder_ctrl_pkg.sv
// Purpose: shared types and default thresholds for the WS2812 bit decoder controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ws2812_bit_decoder_ctrl_pkg;

   localparam int PIXEL_W          = 24;   // GRB word width
   localparam int CNT_W            = 10;   // pulse-width counter width
   localparam int DEF_CE_DIV       = 5;    // 100 ns tick at 50 MHz
   localparam int DEF_BIT_THRESH   = 5;
   localparam int DEF_MAX_HIGH     = 12;
   localparam int DEF_RESET_TICKS  = 400;

   typedef logic [PIXEL_W-1:0] pixel_t;

   typedef struct packed {
      logic rising;
      logic falling;
   } edges_t;

   typedef struct packed {
      logic [CNT_W-1:0] counter;
   } decoder_input_t;

   typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} dec_state_e;

endpackage

// File: rtl/ws2812_bit_decoder_ctrl_if.sv
// Purpose: pixel valid/ready channel from the decoder controller to the pixel consumer.
// Latency: n/a (wiring only).
// Backpressure: consumer drives pixel_ready; producer holds pixel stable while valid && !ready.
// Ports: pixel (GRB word), pixel_valid, pixel_ready; master = producer, slave = consumer.
interface ws2812_bit_decoder_ctrl_if;
   import ws2812_bit_decoder_ctrl_pkg::*;

   pixel_t pixel;
   logic   pixel_valid;
   logic   pixel_ready;

   modport master (output pixel, output pixel_valid, input  pixel_ready);
   modport slave  (input  pixel, input  pixel_valid, output pixel_ready);

endinterface

// File: rtl/ws2812_tick_gen.sv
// Purpose: count-enable prescaler for the pulse-width counter, restarted by any line edge.
// Latency: o_count_enable is combinational from the prescaler register; first tick CE_DIV-1 cycles after restart.
// Backpressure: none.
// Ports: i_clk, i_reset_n, i_restart (any edge flag), o_count_enable.
module ws2812_tick_gen #(
   parameter int CE_DIV = 5
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_restart,
   output logic o_count_enable
);

   localparam int              PRE_W    = $clog2(CE_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CE_DIV - 1);

   logic [PRE_W-1:0] pre;

   // Restarting on every edge aligns tick phase to the edge, so a phase of
   // N clocks reads back as floor((N-1)/CE_DIV) ticks.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         pre <= '0;
      end else if (i_restart || pre == PRE_LAST) begin
         pre <= '0;
      end else begin
         pre <= pre + PRE_W'(1);
      end
   end

   assign o_count_enable = (pre == PRE_LAST);

endmodule

// File: rtl/ws2812_bit_decoder_ctrl.sv
// Purpose: classify WS2812 high pulses into bits, assemble 24-bit GRB pixels, detect reset gaps.
// Latency: pixel valid one cycle after the 24th falling edge; frame_end/error one cycle after the cause.
// Backpressure: one-entry output buffer; a new pixel arriving while valid && !ready is dropped and flagged.
// Ports: i_clk, i_reset_n, i_edges, i_decoder_input (tick count), o_count_enable,
//        pix (pixel channel, master), o_frame_end, o_error.
module ws2812_bit_decoder_ctrl
   import ws2812_bit_decoder_ctrl_pkg::*;
#(
   parameter int CE_DIV      = DEF_CE_DIV,
   parameter int BIT_THRESH  = DEF_BIT_THRESH,
   parameter int MAX_HIGH    = DEF_MAX_HIGH,
   parameter int RESET_TICKS = DEF_RESET_TICKS
) (
   input  logic                         i_clk,
   input  logic                         i_reset_n,
   input  edges_t                       i_edges,
   input  decoder_input_t               i_decoder_input,
   output logic                         o_count_enable,
   ws2812_bit_decoder_ctrl_if.master    pix,
   output logic                         o_frame_end,
   output logic                         o_error
);

   localparam logic [CNT_W-1:0] C_THRESH = CNT_W'(BIT_THRESH);
   localparam logic [CNT_W-1:0] C_MAX    = CNT_W'(MAX_HIGH);
   localparam logic [CNT_W-1:0] C_STUCK  = CNT_W'(MAX_HIGH + 1);
   localparam logic [CNT_W-1:0] C_GAP    = CNT_W'(RESET_TICKS);
   localparam logic [4:0]       LAST_BIT = 5'(PIXEL_W - 1);

   dec_state_e       state;
   logic [4:0]       bit_cnt;
   pixel_t           shift;

   logic [CNT_W-1:0] c;
   logic             rise;
   logic             fall;
   logic             bit_val;
   pixel_t           shift_next;
   logic             good_fall;
   logic             load;
   logic             accept;

   ws2812_tick_gen #(.CE_DIV(CE_DIV)) u_tick_gen (
      .i_clk          (i_clk),
      .i_reset_n      (i_reset_n),
      .i_restart      (i_edges.rising | i_edges.falling),
      .o_count_enable (o_count_enable)
   );

   assign c          = i_decoder_input.counter;
   assign rise       = i_edges.rising;
   assign fall       = i_edges.falling;
   assign bit_val    = (c >= C_THRESH);
   assign shift_next = {shift[PIXEL_W-2:0], bit_val};

   // A falling edge that ends a legal-width high pulse; the 24th one completes a pixel.
   assign good_fall  = (state == HIGH) && fall && !rise && (c != '0) && (c <= C_MAX);
   assign load       = good_fall && (bit_cnt == LAST_BIT);
   assign accept     = pix.pixel_valid && pix.pixel_ready;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state           <= SYNC;
         bit_cnt         <= '0;
         shift           <= '0;
         pix.pixel       <= '0;
         pix.pixel_valid <= 1'b0;
         o_frame_end     <= 1'b0;
         o_error         <= 1'b0;
      end else begin
         o_frame_end <= 1'b0;
         o_error     <= 1'b0;

         // Output buffer: overflow drops the new word and keeps the held one stable.
         if (load) begin
            if (!pix.pixel_valid || pix.pixel_ready) begin
               pix.pixel       <= shift_next;
               pix.pixel_valid <= 1'b1;
            end else begin
               o_error <= 1'b1;
            end
         end else if (accept) begin
            pix.pixel_valid <= 1'b0;
         end

         if (rise && fall) begin
            o_error <= 1'b1;
            state   <= SYNC;
            bit_cnt <= '0;
            shift   <= '0;
         end else begin
            case (state)
               SYNC: begin
                  // Wait for a quiet line long enough to be a reset gap; no frame_end here.
                  if (!rise && !fall && c >= C_GAP) state <= IDLE;
               end
               IDLE: begin
                  if (rise) begin
                     state <= HIGH;
                  end else if (fall) begin
                     o_error <= 1'b1;
                     state   <= SYNC;
                     bit_cnt <= '0;
                     shift   <= '0;
                  end
               end
               HIGH: begin
                  if (good_fall) begin
                     shift   <= shift_next;
                     bit_cnt <= load ? 5'd0 : bit_cnt + 5'd1;
                     state   <= LOW;
                  end else if (rise || fall || c >= C_STUCK) begin
                     // Covers zero/over-long pulses, a stray rising edge and a stuck-high line.
                     o_error <= 1'b1;
                     state   <= SYNC;
                     bit_cnt <= '0;
                     shift   <= '0;
                  end
               end
               LOW: begin
                  if (rise) begin
                     state <= HIGH;
                  end else if (!fall && c >= C_GAP) begin
                     state       <= IDLE;
                     o_frame_end <= 1'b1;
                     if (bit_cnt != '0) begin
                        // Frame ended mid-pixel: discard the partial word.
                        o_error <= 1'b1;
                        bit_cnt <= '0;
                        shift   <= '0;
                     end
                  end
               end
               default: begin
                  state   <= SYNC;
                  bit_cnt <= '0;
                  shift   <= '0;
               end
            endcase
         end
      end
   end

endmodule
